// File: rtl/cipher256_if.sv
// Data/result bundle between the AES-256 round datapath and its environment.
// The cipher takes the slave side; the driver (key expander plus source) takes the master side.
interface cipher256_if;
  logic [127:0] plaintext;
  logic [127:0] roundKey;
  logic         done;
  logic [127:0] cyphertext;

  modport master (
    output plaintext,
    output roundKey,
    input  done,
    input  cyphertext
  );

  modport slave (
    input  plaintext,
    input  roundKey,
    output done,
    output cyphertext
  );
endinterface

// File: rtl/cipher256.sv
// Iterative AES-256 encryption: one round per clock, round keys streamed in by the expander.
// Define CIPHER256_ZEROIZE_EN to keep cyphertext at zero until the final round has been applied.
module cipher256 (
  input  logic        clk,
  input  logic        reset,
  cipher256_if.slave  bus
);

  localparam logic [3:0] RND_FIRST = 4'd0;
  localparam logic [3:0] RND_LAST  = 4'd14;
  localparam logic [3:0] RND_BAD   = 4'd15;

  // FIPS-197 S-box; entry 0 sits in the most significant byte.
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = SBOX_TBL[8'hff - b];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    subword = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte k = 4*col + row; row r of the output takes column (c + r) mod 4 of the input.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    shift_rows = {s[127:120], s[87:80],   s[47:40],  s[7:0],
                  s[95:88],   s[55:48],   s[15:8],   s[103:96],
                  s[63:56],   s[23:16],   s[111:104], s[71:64],
                  s[31:24],   s[119:112], s[79:72],  s[39:32]};
  endfunction

  logic [127:0] s_q;
  logic [127:0] s_d;
  logic [3:0]   rnd_q;
  logic [3:0]   rnd_d;
  logic         done_q;
  logic         done_d;
  logic [127:0] sub_s;
  logic [127:0] sr_s;
  logic [127:0] mc_s;

  // Round datapath: SubBytes, ShiftRows, MixColumns of the current state.
  always_comb begin
    sub_s = {subword(s_q[127:96]), subword(s_q[95:64]),
             subword(s_q[63:32]),  subword(s_q[31:0])};
    sr_s  = shift_rows(sub_s);
    mc_s  = {mix_column(sr_s[127:96]), mix_column(sr_s[95:64]),
             mix_column(sr_s[63:32]),  mix_column(sr_s[31:0])};
  end

  // Round sequencing: initial key add, 13 full rounds, final round, then hold.
  always_comb begin
    s_d    = s_q;
    rnd_d  = rnd_q;
    done_d = done_q;
    if (done_q) begin
      s_d    = s_q;
      rnd_d  = rnd_q;
      done_d = 1'b1;
    end else begin
      case (rnd_q)
        RND_FIRST: begin
          s_d   = bus.plaintext ^ bus.roundKey;
          rnd_d = 4'd1;
        end
        RND_LAST: begin
          s_d    = sr_s ^ bus.roundKey;
          done_d = 1'b1;
        end
        RND_BAD: begin
          s_d   = s_q;
          rnd_d = rnd_q;
        end
        default: begin
          s_d   = mc_s ^ bus.roundKey;
          rnd_d = rnd_q + 4'd1;
        end
      endcase
    end
  end

  // State, round counter and completion flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q    <= 128'h0;
      rnd_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      rnd_q  <= rnd_d;
      done_q <= done_d;
    end
  end

  assign bus.done = done_q;

`ifdef CIPHER256_ZEROIZE_EN
  logic [127:0] ct_q;
  logic [127:0] ct_d;

  // Output copy that only ever carries the finished block.
  always_comb begin
    if (done_d) begin
      ct_d = s_d;
    end else begin
      ct_d = 128'h0;
    end
  end

  // Registered, zeroized result.
  always_ff @(posedge clk) begin
    if (reset) begin
      ct_q <= 128'h0;
    end else begin
      ct_q <= ct_d;
    end
  end

  assign bus.cyphertext = ct_q;
`else
  assign bus.cyphertext = s_q;
`endif

endmodule

// File: tb/tb_cipher256.sv
// Directed bench for cipher256: FIPS-197 C.3 and SP800-38A F.1.5 blocks, aborts, hold and reset.
// Round keys come from an independent key-schedule model built on an algebraic S-box.
module tb_cipher256;

  logic clk = 1'b0;
  logic reset;
  cipher256_if bus ();

  cipher256 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [127:0] rk [0:14];

  localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] R0_C3   = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [255:0] KEY_F15 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] PT_F15  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_F15  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword_ref(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  task automatic expand_key(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subword_ref({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        t = subword_ref(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int k = 0; k < 15; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Called #1 after an edge at which reset was sampled high.
  task automatic start_block(input logic [127:0] pt, input logic [255:0] key);
    expand_key(key);
    bus.plaintext = pt;
    bus.roundKey  = rk[0];
    reset         = 1'b0;
  endtask

  // Advance to edge e of the block and present the key for the following cycle.
  task automatic step(input int e);
    @(posedge clk);
    #1;
    if (e < 15) begin
      bus.roundKey = rk[e];
    end else begin
      bus.roundKey = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic run_full(input string name, input logic [127:0] pt, input logic [255:0] key,
                          input logic [127:0] ct, input logic [127:0] r0);
    start_block(pt, key);
    for (int e = 1; e <= 15; e++) begin
      step(e);
      if (e == 1) begin
`ifdef CIPHER256_ZEROIZE_EN
        check({name, "_r0_zeroized"}, bus.cyphertext, 128'h0);
`else
        check({name, "_r0_state"}, bus.cyphertext, r0);
`endif
      end
      if (e < 15) begin
        check({name, "_done_low"}, {127'h0, bus.done}, 128'h0);
`ifdef CIPHER256_ZEROIZE_EN
        check({name, "_ct_hidden"}, bus.cyphertext, 128'h0);
`endif
      end else begin
        check({name, "_done_e15"}, {127'h0, bus.done}, 128'h1);
        check({name, "_ct"}, bus.cyphertext, ct);
      end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.plaintext = 128'h0;
    bus.roundKey  = 128'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {127'h0, bus.done}, 128'h0);
    check("reset_ct", bus.cyphertext, 128'h0);

    run_full("c3", PT_C3, KEY_C3, CT_C3, R0_C3);

    // Inputs churn while done holds the result.
    for (int i = 0; i < 20; i++) begin
      bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
      bus.roundKey  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      check("hold_done", {127'h0, bus.done}, 128'h1);
      check("hold_ct", bus.cyphertext, CT_C3);
    end

    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_after_done_done", {127'h0, bus.done}, 128'h0);
    check("rst_after_done_ct", bus.cyphertext, 128'h0);

    // Abort a C.3 run with reset at edge 7, then run F.1.5.
    start_block(PT_C3, KEY_C3);
    for (int e = 1; e <= 6; e++) step(e);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_done", {127'h0, bus.done}, 128'h0);
    check("abort_ct", bus.cyphertext, 128'h0);

    run_full("f15", PT_F15, KEY_F15, CT_F15, PT_F15 ^ KEY_F15[255:128]);

    // Back-to-back with a single-cycle reset pulse.
    reset = 1'b1;
    @(posedge clk);
    #1;
    run_full("c3_again", PT_C3, KEY_C3, CT_C3, R0_C3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
